multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rv32i_ctrl_pkg.sv | 73 +++++++
 rtl/alu_dec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// The state enum, opcodes and datapath mux selects are defined here so the FSM and ALU decoder agree.
package rv32i_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_AUIPC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_RTYPE,
    ALUOP_ITYPE
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_READ = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Unknown opcodes fall back to FETCH, so they retire as a NOP.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_RTYPE:          return S_EXECR;
      OP_ITYPE:          return S_EXECI;
      OP_AUIPC:          return S_AUIPC;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      default:           return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: turns the FSM's coarse alu_op plus funct fields into alu_control.
module alu_dec
  import rv32i_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // funct7b5 only selects sub for register-register ops; immediates ignore it.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000:  alu_control = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle RV32I datapath.
// Outputs decode from state; the only input-dependent enables are memory-handshake and branch pc_write.
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control
);

  state_t  state;
  alu_op_t alu_op;
  logic    mem_ok;
  logic    branch_taken;

  assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:                   if (mem_ok) state <= S_DECODE;
        S_DECODE:                  state <= decode_next(opcode);
        S_MEMADR:                  state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:                 if (mem_ok) state <= S_MEMWB;
        S_MEMWRITE:                if (mem_ok) state <= S_FETCH;
        S_EXECR, S_EXECI, S_AUIPC: state <= S_ALUWB;
        default:                   state <= S_FETCH;
      endcase
    end
  end

  // Write enables are masked during reset so an interrupted store or writeback cannot leak out.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_READ;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_RTYPE;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYPE;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_write  = branch_taken;
      end
      S_JAL: begin
        result_src = RES_PC4;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_PC4;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, multi-cycle corner sequences,
// then random instructions compared against a per-instruction cycle-script model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
  } ctrl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic [3:0] wr;
    logic       rs_chk;
    logic [1:0] rs;
    logic       alu_chk;
    logic [2:0] alu3;
  } vec_t;

  typedef enum {K_FETCH, K_DECODE, K_ADDR, K_RD, K_RDWB, K_WR, K_ALUR, K_ALUI,
                K_AUIPC, K_WB, K_BR, K_JAL, K_JALR, K_LUI} kind_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  ctrl_t      act;
  int         n_checks = 0;
  int         n_fail = 0;
  kind_e      plan_q[$];

  assign act = {pc_write, ir_write, reg_write, mem_write, adr_src,
                result_src, alu_src_a, alu_src_b, alu_control};

  always #5 clk = ~clk;

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control)
  );

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input logic mr, input logic rst);
    opcode    = op;
    funct3    = f3;
    funct7b5  = f7;
    zero      = z;
    mem_ready = mr;
    reset     = rst;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from a FETCH cycle until the next FETCH; stall bit i drops mem_ready in cycle i.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                          input logic [15:0] stall, output int lat, output ctrl_t last, output ctrl_t third);
    ctrl_t c;
    lat   = -1;
    last  = '0;
    third = '0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(op, f3, f7, z, ~stall[i], 1'b0);
      @(negedge clk);
      c = act;
      if (i > 0 && c.b == 2'b10) begin
        lat = i;
        break;
      end
      last = c;
      if (i == 2) third = c;
      nextCycle();
    end
    mem_ready = 1'b0;
    nextCycle();
  endtask

  function automatic logic [2:0] refAlu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Cycle script of an instruction: fetch, decode, then the opcode's execution steps.
  task automatic buildPlan(input logic [6:0] op);
    plan_q.delete();
    plan_q.push_back(K_FETCH);
    plan_q.push_back(K_DECODE);
    case (op)
      7'b0000011: begin plan_q.push_back(K_ADDR); plan_q.push_back(K_RD); plan_q.push_back(K_RDWB); end
      7'b0100011: begin plan_q.push_back(K_ADDR); plan_q.push_back(K_WR); end
      7'b0110011: begin plan_q.push_back(K_ALUR); plan_q.push_back(K_WB); end
      7'b0010011: begin plan_q.push_back(K_ALUI); plan_q.push_back(K_WB); end
      7'b0010111: begin plan_q.push_back(K_AUIPC); plan_q.push_back(K_WB); end
      7'b1100011: plan_q.push_back(K_BR);
      7'b1101111: plan_q.push_back(K_JAL);
      7'b1100111: plan_q.push_back(K_JALR);
      7'b0110111: plan_q.push_back(K_LUI);
      default: ;
    endcase
  endtask

  function automatic logic waitsOnMem(input kind_e k);
    return (k == K_FETCH || k == K_RD || k == K_WR);
  endfunction

  // Expected outputs for one step; m marks the fields the step actually defines.
  task automatic expectCtrl(input kind_e k, input logic [2:0] f3, input logic f7, input logic z,
                            input logic mr, output ctrl_t e, output ctrl_t m);
    e = '0;
    m = '0;
    m.pcw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.mw = 1'b1;
    case (k)
      K_FETCH:  begin m = '1; e.b = 2'b10; e.pcw = mr; e.irw = mr; end
      K_DECODE: begin m.a = '1; m.b = '1; m.alu = '1; e.a = 2'b01; e.b = 2'b01; end
      K_ADDR:   begin m.a = '1; m.b = '1; m.alu = '1; e.a = 2'b10; e.b = 2'b01; end
      K_RD:     begin m.adr = 1'b1; m.rs = '1; e.adr = 1'b1; end
      K_RDWB:   begin m.rs = '1; e.rs = 2'b01; e.rw = 1'b1; end
      K_WR:     begin m.adr = 1'b1; m.rs = '1; e.adr = 1'b1; e.mw = 1'b1; end
      K_ALUR:   begin m.a = '1; m.b = '1; m.alu = '1; e.a = 2'b10; e.b = 2'b00; e.alu = refAlu(f3, f7, 1'b1); end
      K_ALUI:   begin m.a = '1; m.b = '1; m.alu = '1; e.a = 2'b10; e.b = 2'b01; e.alu = refAlu(f3, f7, 1'b0); end
      K_AUIPC:  begin m.a = '1; m.b = '1; m.alu = '1; e.a = 2'b01; e.b = 2'b01; end
      K_WB:     begin m.rs = '1; e.rw = 1'b1; end
      K_BR: begin
        m.a = '1; m.b = '1; m.alu = '1; m.rs = '1;
        e.a = 2'b10; e.alu = 3'b001;
        e.pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
      end
      K_JAL:    begin m.rs = '1; e.rs = 2'b10; e.rw = 1'b1; e.pcw = 1'b1; end
      K_JALR: begin
        m.a = '1; m.b = '1; m.alu = '1; m.rs = '1;
        e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.rw = 1'b1; e.pcw = 1'b1;
      end
      K_LUI:    begin m.rs = '1; e.rs = 2'b11; e.rw = 1'b1; end
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[22];
    logic [6:0] legal_ops[9];
    int         lat, sel;
    ctrl_t      last, third, e, m;
    logic [6:0] rop;
    logic [2:0] rf3;
    logic       rf7, rmr, rz, rrst;

    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b000};
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[2]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b101};
    vecs[3]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b011};
    vecs[4]  = '{7'b0110011, 3'b111, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b010};
    vecs[5]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b000};
    vecs[6]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b000};
    vecs[7]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b011};
    vecs[8]  = '{7'b0010011, 3'b010, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b101};
    vecs[9]  = '{7'b0010111, 3'b000, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 2'b00, 1'b1, 3'b000};
    vecs[10] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'b0010, 1'b1, 2'b01, 1'b1, 3'b000};
    vecs[11] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'b0001, 1'b1, 2'b00, 1'b1, 3'b000};
    vecs[12] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'b1000, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[13] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'b0000, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[14] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 4'b1000, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[15] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 4'b0000, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[16] = '{7'b1100011, 3'b100, 1'b0, 1'b1, 3, 4'b0000, 1'b1, 2'b00, 1'b1, 3'b001};
    vecs[17] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 3, 4'b1010, 1'b1, 2'b10, 1'b0, 3'b000};
    vecs[18] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 3, 4'b1010, 1'b1, 2'b10, 1'b1, 3'b000};
    vecs[19] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 3, 4'b0010, 1'b1, 2'b11, 1'b0, 3'b000};
    vecs[20] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 3'b000};
    vecs[21] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 3'b000};

    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0010111,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    // Reset holds write enables low even with mem_ready high in FETCH.
    applyStimulus(7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("reset_we", {28'd0, act.pcw, act.irw, act.rw, act.mw}, 32'd0);
    nextCycle();
    applyStimulus(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    e = '0;
    e.b = 2'b10;
    checkOutput("post_reset_fetch", {18'd0, act}, {18'd0, e});
    mem_ready = 1'b1;
    #1;
    checkOutput("fetch_ready_we", {30'd0, act.pcw, act.irw}, 32'd3);
    nextCycle();
    @(negedge clk);
    checkOutput("illegal_decode_we", {28'd0, act.pcw, act.irw, act.rw, act.mw}, 32'd0);
    checkOutput("illegal_decode_src", {28'd0, act.a, act.b}, 32'h5);
    nextCycle();
    @(negedge clk);
    checkOutput("illegal_back_to_fetch", {30'd0, act.b}, 32'd2);
    mem_ready = 1'b0;
    nextCycle();

    for (int k = 0; k < 22; k++) begin
      runInstr(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].z, 16'h0000, lat, last, third);
      checkOutput($sformatf("vec%0d_latency", k), lat, vecs[k].lat);
      checkOutput($sformatf("vec%0d_last_we", k), {28'd0, last.pcw, last.irw, last.rw, last.mw}, {28'd0, vecs[k].wr});
      if (vecs[k].rs_chk) checkOutput($sformatf("vec%0d_last_rs", k), {30'd0, last.rs}, {30'd0, vecs[k].rs});
      if (vecs[k].alu_chk) checkOutput($sformatf("vec%0d_cycle3_alu", k), {29'd0, third.alu}, {29'd0, vecs[k].alu3});
    end

    // Load with two wait cycles in MEMREAD.
    runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 16'b0000_0000_0001_1000, lat, last, third);
    checkOutput("lw_stall_latency", lat, 7);
    checkOutput("lw_stall_wb_rs", {30'd0, last.rs}, 32'd1);
    checkOutput("lw_stall_wb_rw", {31'd0, last.rw}, 32'd1);

    // Store stalled in MEMWRITE, then reset lands mid-access.
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    nextCycle();
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("sw_memwrite_mw", {31'd0, act.mw}, 32'd1);
    checkOutput("sw_memwrite_adr", {31'd0, act.adr}, 32'd1);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("sw_reset_we", {28'd0, act.pcw, act.irw, act.rw, act.mw}, 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("sw_after_reset_mw", {31'd0, act.mw}, 32'd0);
    e = '0;
    e.b = 2'b10;
    checkOutput("sw_after_reset_fetch", {18'd0, act}, {18'd0, e});
    nextCycle();

    rop = 7'd0; rf3 = 3'd0; rf7 = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (plan_q.size() == 0) begin
        sel = $urandom_range(0, 9);
        rop = (sel == 9) ? 7'($urandom) : legal_ops[sel];
        rf3 = 3'($urandom);
        rf7 = 1'($urandom);
        buildPlan(rop);
      end
      rmr  = ($urandom_range(0, 3) != 0);
      rz   = 1'($urandom);
      rrst = ($urandom_range(0, 59) == 0);
      applyStimulus(rop, rf3, rf7, rz, rmr, rrst);
      @(negedge clk);
      if (rrst) begin
        checkOutput("rand_reset_we", {28'd0, act.pcw, act.irw, act.rw, act.mw}, 32'd0);
        plan_q.delete();
      end else begin
        expectCtrl(plan_q[0], rf3, rf7, rz, rmr, e, m);
        checkOutput($sformatf("rand_ctrl_step%0d_op%07b", plan_q[0], rop), {18'd0, act & m}, {18'd0, e & m});
        checkOutput("rand_we_exclusive", {31'd0, act.rw & act.mw}, 32'd0);
        if (!(waitsOnMem(plan_q[0]) && !rmr)) void'(plan_q.pop_front());
      end
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
